// File: rtl/op_sequencer.sv
// Micro-sequencer that expands one ALU instruction into the bus-drive and
// load-enable control steps of a single-bus datapath (IDLE/LDY/EXEC/WBLO/WBHI).
module op_sequencer #(
  parameter int NREGS      = 16,
  parameter int RW         = $clog2(NREGS),
  parameter bit PROTECT_R0 = 1'b1
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [RW-1:0]    ra,
  input  logic [RW-1:0]    rb,
  input  logic [RW-1:0]    rc,
  output logic [NREGS-1:0] Rout,
  output logic             ZHIout,
  output logic             ZLOout,
  output logic             Yin,
  output logic             ZHIin,
  output logic             ZLOin,
  output logic             HIin,
  output logic             LOin,
  output logic [NREGS-1:0] Rin,
  output logic [12:0]      alu_op,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LDY  = 3'd1,
    EXEC = 3'd2,
    WBLO = 3'd3,
    WBHI = 3'd4
  } state_t;

  localparam logic [3:0] OP_MUL = 4'd9;
  localparam logic [3:0] OP_DIV = 4'd10;
  localparam logic [3:0] OP_NEG = 4'd11;
  localparam logic [3:0] OP_NOT = 4'd12;

  localparam logic [NREGS-1:0] ONE_HOT_BASE = {{(NREGS-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [3:0]    opcode_q, opcode_d;
  logic [RW-1:0] ra_q, ra_d;
  logic [RW-1:0] rb_q, rb_d;
  logic [RW-1:0] rc_q, rc_d;
  logic          err_q, err_d;

  logic in_illegal;
  logic in_unary;
  logic op_unary;
  logic op_muldiv;
  logic rc_protected;

  assign in_illegal   = (opcode > OP_NOT);
  assign in_unary     = (opcode == OP_NEG) || (opcode == OP_NOT);
  assign op_unary     = (opcode_q == OP_NEG) || (opcode_q == OP_NOT);
  assign op_muldiv    = (opcode_q == OP_MUL) || (opcode_q == OP_DIV);
  assign rc_protected = PROTECT_R0 && (rc_q == '0);

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q  <= IDLE;
      opcode_q <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      rc_q     <= rc_d;
      err_q    <= err_d;
    end
  end

  // Fields are captured only on acceptance so later input changes cannot disturb a running instruction.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    rc_d     = rc_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (in_illegal) begin
            err_d = 1'b1;
          end else begin
            opcode_d = opcode;
            ra_d     = ra;
            rb_d     = rb;
            rc_d     = rc;
            state_d  = in_unary ? EXEC : LDY;
          end
        end
      end
      LDY:     state_d = EXEC;
      EXEC:    state_d = WBLO;
      WBLO:    state_d = op_muldiv ? WBHI : IDLE;
      WBHI:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode only registered state, so IDLE (and therefore reset) drives everything low.
  always_comb begin
    Rout   = '0;
    Rin    = '0;
    ZHIout = 1'b0;
    ZLOout = 1'b0;
    Yin    = 1'b0;
    ZHIin  = 1'b0;
    ZLOin  = 1'b0;
    HIin   = 1'b0;
    LOin   = 1'b0;
    alu_op = '0;
    done   = 1'b0;
    busy   = (state_q != IDLE);
    err    = err_q;
    case (state_q)
      LDY: begin
        Rout = ONE_HOT_BASE << ra_q;
        Yin  = 1'b1;
      end
      EXEC: begin
        Rout   = ONE_HOT_BASE << (op_unary ? ra_q : rb_q);
        alu_op = 13'd1 << opcode_q;
        ZLOin  = 1'b1;
        ZHIin  = op_muldiv;
      end
      WBLO: begin
        ZLOout = 1'b1;
        if (op_muldiv) begin
          LOin = 1'b1;
        end else begin
          Rin  = rc_protected ? '0 : (ONE_HOT_BASE << rc_q);
          done = 1'b1;
        end
      end
      WBHI: begin
        ZHIout = 1'b1;
        HIin   = 1'b1;
        done   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_op_sequencer.sv
// Directed self-checking bench for op_sequencer: walks ADD, MUL, NOT, illegal,
// protected-R0, back-to-back start and mid-instruction Clear scenarios.
module tb_op_sequencer;

  localparam int NREGS = 16;
  localparam int RW    = 4;

  // Flag vector layout: {ZHIout,ZLOout,Yin,ZHIin,ZLOin,HIin,LOin,busy,done,err}
  localparam logic [9:0] F_ZHIOUT = 10'b10_0000_0000;
  localparam logic [9:0] F_ZLOOUT = 10'b01_0000_0000;
  localparam logic [9:0] F_YIN    = 10'b00_1000_0000;
  localparam logic [9:0] F_ZHIIN  = 10'b00_0100_0000;
  localparam logic [9:0] F_ZLOIN  = 10'b00_0010_0000;
  localparam logic [9:0] F_HIIN   = 10'b00_0001_0000;
  localparam logic [9:0] F_LOIN   = 10'b00_0000_1000;
  localparam logic [9:0] F_BUSY   = 10'b00_0000_0100;
  localparam logic [9:0] F_DONE   = 10'b00_0000_0010;
  localparam logic [9:0] F_ERR    = 10'b00_0000_0001;

  logic             Clock;
  logic             Clear;
  logic             start;
  logic [3:0]       opcode;
  logic [RW-1:0]    ra, rb, rc;
  logic [NREGS-1:0] Rout, Rin;
  logic             ZHIout, ZLOout, Yin, ZHIin, ZLOin, HIin, LOin;
  logic [12:0]      alu_op;
  logic             busy, done, err;

  int nChecks = 0;
  int nFails  = 0;

  op_sequencer #(.NREGS(NREGS), .RW(RW), .PROTECT_R0(1'b1)) dut (
    .Clock  (Clock),
    .Clear  (Clear),
    .start  (start),
    .opcode (opcode),
    .ra     (ra),
    .rb     (rb),
    .rc     (rc),
    .Rout   (Rout),
    .ZHIout (ZHIout),
    .ZLOout (ZLOout),
    .Yin    (Yin),
    .ZHIin  (ZHIin),
    .ZLOin  (ZLOin),
    .HIin   (HIin),
    .LOin   (LOin),
    .Rin    (Rin),
    .alu_op (alu_op),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic applyStimulus(input logic s, input logic [3:0] op,
                               input logic [RW-1:0] a, input logic [RW-1:0] b,
                               input logic [RW-1:0] c);
    start  = s;
    opcode = op;
    ra     = a;
    rb     = b;
    rc     = c;
  endtask

  task automatic stepCycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [NREGS-1:0] expRout,
                             input logic [12:0] expAlu, input logic [NREGS-1:0] expRin,
                             input logic [9:0] expFlags);
    logic [9:0] flags;
    flags = {ZHIout, ZLOout, Yin, ZHIin, ZLOin, HIin, LOin, busy, done, err};
    nChecks++;
    assert (Rout === expRout) else begin
      nFails++;
      $error("[TB] FAIL %s Rout observed=%h expected=%h", tag, Rout, expRout);
    end
    nChecks++;
    assert (alu_op === expAlu) else begin
      nFails++;
      $error("[TB] FAIL %s alu_op observed=%h expected=%h", tag, alu_op, expAlu);
    end
    nChecks++;
    assert (Rin === expRin) else begin
      nFails++;
      $error("[TB] FAIL %s Rin observed=%h expected=%h", tag, Rin, expRin);
    end
    nChecks++;
    assert (flags === expFlags) else begin
      nFails++;
      $error("[TB] FAIL %s flags observed=%b expected=%b", tag, flags, expFlags);
    end
  endtask

  initial begin
    Clear = 1'b1;
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    #2;
    checkOutput("reset_t0", 16'h0000, 13'h0000, 16'h0000, 10'b0);
    applyStimulus(1'b1, 4'd0, 4'd1, 4'd2, 4'd3);
    stepCycle();
    stepCycle();
    checkOutput("reset_held_start", 16'h0000, 13'h0000, 16'h0000, 10'b0);

    // ADD R7 = R2 + R5, accepted on the first edge after Clear drops; inputs scrambled afterwards
    Clear = 1'b0;
    applyStimulus(1'b1, 4'd0, 4'd2, 4'd5, 4'd7);
    stepCycle();
    applyStimulus(1'b0, 4'd9, 4'd1, 4'd1, 4'd1);
    checkOutput("add_c1", 16'h0004, 13'h0000, 16'h0000, F_YIN | F_BUSY);
    stepCycle();
    checkOutput("add_c2", 16'h0020, 13'h0001, 16'h0000, F_ZLOIN | F_BUSY);
    stepCycle();
    checkOutput("add_c3", 16'h0000, 13'h0000, 16'h0080, F_ZLOOUT | F_BUSY | F_DONE);
    stepCycle();
    checkOutput("add_idle", 16'h0000, 13'h0000, 16'h0000, 10'b0);

    // MUL R1 * R2
    applyStimulus(1'b1, 4'd9, 4'd1, 4'd2, 4'd3);
    stepCycle();
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    checkOutput("mul_c1", 16'h0002, 13'h0000, 16'h0000, F_YIN | F_BUSY);
    stepCycle();
    checkOutput("mul_c2", 16'h0004, 13'h0200, 16'h0000, F_ZHIIN | F_ZLOIN | F_BUSY);
    stepCycle();
    checkOutput("mul_c3", 16'h0000, 13'h0000, 16'h0000, F_ZLOOUT | F_LOIN | F_BUSY);
    stepCycle();
    checkOutput("mul_c4", 16'h0000, 13'h0000, 16'h0000, F_ZHIOUT | F_HIIN | F_BUSY | F_DONE);
    stepCycle();
    checkOutput("mul_idle", 16'h0000, 13'h0000, 16'h0000, 10'b0);

    // NOT R6 = ~R4, no Y load
    applyStimulus(1'b1, 4'd12, 4'd4, 4'd9, 4'd6);
    stepCycle();
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    checkOutput("not_c1", 16'h0010, 13'h1000, 16'h0000, F_ZLOIN | F_BUSY);
    stepCycle();
    checkOutput("not_c2", 16'h0000, 13'h0000, 16'h0040, F_ZLOOUT | F_BUSY | F_DONE);
    stepCycle();
    checkOutput("not_idle", 16'h0000, 13'h0000, 16'h0000, 10'b0);

    // Illegal opcode 14
    applyStimulus(1'b1, 4'd14, 4'd1, 4'd2, 4'd3);
    stepCycle();
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    checkOutput("ill_err", 16'h0000, 13'h0000, 16'h0000, F_ERR);
    stepCycle();
    checkOutput("ill_after", 16'h0000, 13'h0000, 16'h0000, 10'b0);

    // SUB into protected R0, with ra == rb
    applyStimulus(1'b1, 4'd1, 4'd3, 4'd3, 4'd0);
    stepCycle();
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    checkOutput("sub_r0_c1", 16'h0008, 13'h0000, 16'h0000, F_YIN | F_BUSY);
    stepCycle();
    checkOutput("sub_r0_c2", 16'h0008, 13'h0002, 16'h0000, F_ZLOIN | F_BUSY);
    stepCycle();
    checkOutput("sub_r0_c3", 16'h0000, 13'h0000, 16'h0000, F_ZLOOUT | F_BUSY | F_DONE);

    // start held high: R3 = R3 + R3 repeats once every 4 cycles
    applyStimulus(1'b1, 4'd0, 4'd3, 4'd3, 4'd3);
    stepCycle();
    checkOutput("hold_idle0", 16'h0000, 13'h0000, 16'h0000, 10'b0);
    stepCycle();
    checkOutput("hold_c1", 16'h0008, 13'h0000, 16'h0000, F_YIN | F_BUSY);
    stepCycle();
    checkOutput("hold_c2", 16'h0008, 13'h0001, 16'h0000, F_ZLOIN | F_BUSY);
    stepCycle();
    checkOutput("hold_c3", 16'h0000, 13'h0000, 16'h0008, F_ZLOOUT | F_BUSY | F_DONE);
    stepCycle();
    checkOutput("hold_c4_idle", 16'h0000, 13'h0000, 16'h0000, 10'b0);
    stepCycle();
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    checkOutput("hold_c5_reaccept", 16'h0008, 13'h0000, 16'h0000, F_YIN | F_BUSY);
    stepCycle();
    stepCycle();
    checkOutput("hold_c7_done", 16'h0000, 13'h0000, 16'h0008, F_ZLOOUT | F_BUSY | F_DONE);
    stepCycle();

    // DIV aborted by Clear during EXEC
    applyStimulus(1'b1, 4'd10, 4'd1, 4'd2, 4'd3);
    stepCycle();
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    stepCycle();
    checkOutput("div_exec", 16'h0004, 13'h0400, 16'h0000, F_ZHIIN | F_ZLOIN | F_BUSY);
    #2;
    Clear = 1'b1;
    #1;
    checkOutput("div_clear_async", 16'h0000, 13'h0000, 16'h0000, 10'b0);
    stepCycle();
    checkOutput("div_clear_held", 16'h0000, 13'h0000, 16'h0000, 10'b0);
    Clear = 1'b0;
    stepCycle();
    checkOutput("div_no_done", 16'h0000, 13'h0000, 16'h0000, 10'b0);

    // ADD R1 = R1 + R1 after abort completes normally
    applyStimulus(1'b1, 4'd0, 4'd1, 4'd1, 4'd1);
    stepCycle();
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    checkOutput("post_add_c1", 16'h0002, 13'h0000, 16'h0000, F_YIN | F_BUSY);
    stepCycle();
    checkOutput("post_add_c2", 16'h0002, 13'h0001, 16'h0000, F_ZLOIN | F_BUSY);
    stepCycle();
    checkOutput("post_add_c3", 16'h0000, 13'h0000, 16'h0002, F_ZLOOUT | F_BUSY | F_DONE);
    stepCycle();
    checkOutput("post_add_idle", 16'h0000, 13'h0000, 16'h0000, 10'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
